arb_rr_4t: RTL and testbench
============================

Name: arb_rr_4t

Overview:
- Four-requester round-robin arbiter with a registered one-hot grant and release handshake.
- It is the responder for the shared request line that the delayed 4-input OR collects: the OR reports that someone is requesting, and this block decides who is served.
- It sits between up to four lab-level requesters (ALU slices, counters) and a single shared resource.

Parameters:
- MAX_HOLD, 8: maximum consecutive cycles one requester may hold the grant before it is forcibly released. Legal range is 1..15.
- HOLD_W, 4: width of the hold counter. It must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk, input, 1: single clock; all state updates on its rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- req, input, 4: request vector; bit i is requester i.
- done, input, 1: the current grant holder finishes its transfer this cycle.
- any_req, output, 1: combinational OR of req[3:0].
- gnt, output, 4: registered one-hot grant; all zeros when nothing is granted.
- gnt_valid, output, 1: registered; 1 exactly when gnt is nonzero.
- gnt_id, output, 2: registered index of the granted requester; holds its last value when gnt_valid=0.

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately even mid-grant):
  - gnt=4'b0000, gnt_valid=0, gnt_id=2'd0.
  - Priority pointer ptr=2'd0, hold_cnt=0, state=IDLE.
- Internal state: 2-bit ptr (the highest-priority index), HOLD_W-bit hold_cnt, 1-bit state {IDLE, GRANT}.
- IDLE:
  - If req!=0 at edge N, the winner is the first set bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - After edge N: gnt=one-hot(winner), gnt_valid=1, gnt_id=winner, hold_cnt=0, state=GRANT. Grant latency is one clock from the sampled request.
  - If req==0, all outputs stay deasserted and ptr is unchanged.
- GRANT: release is triggered at an edge when any of the following holds:
  - done=1;
  - req[gnt_id]=0 (the requester withdrew);
  - hold_cnt==MAX_HOLD-1 (forced release, timeout).
- On release:
  - gnt=0 and gnt_valid=0; gnt_id is held.
  - ptr=gnt_id+1 mod 4 (wraps 3 to 0); state=IDLE.
- Without release: hold_cnt increments by 1 and gnt is unchanged.
- One mandatory dead cycle (gnt=0) always separates consecutive grants, including re-grant to the same requester.
- A requester holds the grant for at most MAX_HOLD cycles.
- Simultaneous events:
  - done together with other requests rising: release wins, then normal arbitration in the following IDLE cycle.
  - done asserted in IDLE: ignored.
  - A new req bit rising during GRANT does not preempt the current holder.
- Fairness: with all four requesting continuously, the grant order is 0,1,2,3,0,... Each requester waits at most 3 grants.
- any_req is purely combinational, has no reset dependence, and reflects req within the same cycle.
- gnt is never multi-hot.

Test Plan:
- Reset mid-grant:
  - Stimulus: hold req=4'b0010 until gnt=4'b0010, then pull rst_n low between clock edges.
  - Response: gnt=0, gnt_valid=0, gnt_id=0 immediately, without waiting for a clock edge.
  - Follow-up: after release, req=4'b1010 gives gnt=4'b0010 first, because ptr reset to 0.
- Round robin:
  - Stimulus: req=4'b1111 held, done pulsed one cycle after each grant.
  - Response: gnt sequence 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001.
- Timeout:
  - Stimulus: MAX_HOLD=8, req=4'b0100 with done=0 throughout.
  - Response: gnt=4'b0100 for exactly 8 cycles, then 0 for 1 cycle, then re-granted to 4'b0100.
- Withdrawal and wrap:
  - Stimulus: with ptr=3, req=4'b1001.
  - Response: gnt=4'b1000, gnt_id=3. After req[3] drops, one dead cycle, then gnt=4'b0001 and ptr wraps to 0 then advances to 1.
- Simultaneous events:
  - Stimulus: done=1 in the same cycle req changes from 4'b0001 to 4'b0110 while 0 is granted.
  - Response: release, one dead cycle, then gnt=4'b0010.
  - Also check: done in IDLE has no effect, and any_req=1 whenever req!=0 with zero cycle latency.

Source files
------------

// File: rtl/arb_rr_4t.sv
// arb_rr_4t: four-requester round-robin arbiter with registered one-hot grant, release handshake and hold timeout
module arb_rr_4t #(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic       any_req,
  output logic [3:0] gnt,
  output logic       gnt_valid,
  output logic [1:0] gnt_id
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_nx;
  logic [1:0] ptr, ptr_nx, off, win, gnt_id_nx;
  logic [HOLD_W-1:0] hold_cnt, hold_nx;
  logic [3:0] gnt_nx, rot;
  logic [7:0] dbl;
  logic gnt_valid_nx, rel;
  assign any_req = |req;
  // rotate so that bit 0 is the highest-priority requester
  assign dbl = {req, req};
  assign rot = dbl[{1'b0, ptr} +: 4];
  assign off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
  assign win = ptr + off;
  assign rel = done | ~req[gnt_id] | (hold_cnt == HOLD_W'(MAX_HOLD - 1));
  always_comb begin
    state_nx = state;
    ptr_nx = ptr;
    hold_nx = hold_cnt;
    gnt_nx = gnt;
    gnt_valid_nx = gnt_valid;
    gnt_id_nx = gnt_id;
    if (state == IDLE) begin
      if (any_req) begin
        state_nx = GRANT;
        gnt_nx = 4'b0001 << win;
        gnt_valid_nx = 1'b1;
        gnt_id_nx = win;
        hold_nx = '0;
      end
    end else if (rel) begin
      state_nx = IDLE;
      gnt_nx = 4'b0000;
      gnt_valid_nx = 1'b0;
      ptr_nx = gnt_id + 2'd1;
    end else begin
      hold_nx = hold_cnt + HOLD_W'(1);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= 2'd0;
      hold_cnt <= '0;
      gnt <= 4'b0000;
      gnt_valid <= 1'b0;
      gnt_id <= 2'd0;
    end else begin
      state <= state_nx;
      ptr <= ptr_nx;
      hold_cnt <= hold_nx;
      gnt <= gnt_nx;
      gnt_valid <= gnt_valid_nx;
      gnt_id <= gnt_id_nx;
    end
  end
endmodule

// File: tb/tb_arb_rr_4t.sv
// tb_arb_rr_4t: directed stimulus with a cycle-level behavioural model checked every negedge plus literal expectations
module tb_arb_rr_4t;
  localparam int MAX_HOLD = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic done = 1'b0;
  logic any_req, gnt_valid;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  int vectors = 0;
  int miscompares = 0;
  int m_holder = -1;
  int m_ptr = 0;
  int m_held = 0;
  int m_last = 0;
  arb_rr_4t #(.MAX_HOLD(MAX_HOLD), .HOLD_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .any_req(any_req), .gnt(gnt), .gnt_valid(gnt_valid), .gnt_id(gnt_id)
  );
  always #20 clk = ~clk;
  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask
  // model: who holds the grant, how long it has held it, and who is next in line
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_holder = -1; m_ptr = 0; m_held = 0; m_last = 0;
    end else if (m_holder < 0) begin
      for (int k = 3; k >= 0; k--)
        if (req[(m_ptr + k) % 4]) m_holder = (m_ptr + k) % 4;
      if (m_holder >= 0) begin
        m_held = 1;
        m_last = m_holder;
      end
    end else if (done || !req[m_holder] || m_held == MAX_HOLD) begin
      m_ptr = (m_holder + 1) % 4;
      m_holder = -1;
    end else begin
      m_held++;
    end
  end
  always @(negedge clk) begin
    check("gnt", gnt, m_holder < 0 ? 4'b0000 : 4'(1 << m_holder));
    check("gnt_valid", {3'b0, gnt_valid}, {3'b0, m_holder >= 0});
    check("gnt_id", {2'b0, gnt_id}, 4'(m_last));
    check("any_req", {3'b0, any_req}, {3'b0, |req});
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  logic [3:0] rr_exp [9] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
  logic [4:0] mix [16] = '{5'b11110, 5'b11110, 5'b11111, 5'b01100, 5'b01100, 5'b00000, 5'b10010,
                           5'b10010, 5'b10011, 5'b00101, 5'b00100, 5'b01010, 5'b11111, 5'b00000, 5'b00011, 5'b00000};
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_gnt", gnt, 4'b0000);
    check("reset_id", {2'b0, gnt_id}, 4'd0);
    rst_n = 1'b1;
    // reset while requester 1 holds the grant
    req = 4'b0010;
    cyc();
    check("pre_reset_gnt", gnt, 4'b0010);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_gnt", gnt, 4'b0000);
    check("async_reset_valid", {3'b0, gnt_valid}, 4'd0);
    check("async_reset_id", {2'b0, gnt_id}, 4'd0);
    cyc();
    rst_n = 1'b1;
    req = 4'b1010;
    cyc();
    check("post_reset_gnt", gnt, 4'b0010);
    check("post_reset_id", {2'b0, gnt_id}, 4'd1);
    req = 4'b0000;
    cyc();
    check("withdraw_gnt", gnt, 4'b0000);
    // round robin from ptr=0
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    req = 4'b1111;
    for (int i = 0; i < 9; i++) begin
      cyc();
      check("rr_seq", gnt, rr_exp[i]);
      done = rr_exp[i] != 4'b0000;
    end
    done = 1'b0;
    req = 4'b0000;
    cyc();
    // timeout: ptr=1, only requester 2 asks
    req = 4'b0100;
    for (int i = 0; i < MAX_HOLD; i++) begin
      cyc();
      check("timeout_hold", gnt, 4'b0100);
    end
    cyc();
    check("timeout_dead", gnt, 4'b0000);
    cyc();
    check("timeout_regrant", gnt, 4'b0100);
    req = 4'b0000;
    cyc();
    // ptr=3: wrap from 3 to 0
    req = 4'b1001;
    cyc();
    check("wrap_gnt3", gnt, 4'b1000);
    check("wrap_id3", {2'b0, gnt_id}, 4'd3);
    req = 4'b0001;
    cyc();
    check("wrap_dead", gnt, 4'b0000);
    cyc();
    check("wrap_gnt0", gnt, 4'b0001);
    req = 4'b0000;
    cyc();
    req = 4'b0011;
    cyc();
    check("ptr_after_wrap", gnt, 4'b0010);
    req = 4'b0000;
    cyc();
    // done together with new requests while 0 holds
    req = 4'b0001;
    cyc();
    check("simul_gnt0", gnt, 4'b0001);
    done = 1'b1;
    req = 4'b0110;
    cyc();
    check("simul_release", gnt, 4'b0000);
    done = 1'b0;
    cyc();
    check("simul_regrant", gnt, 4'b0010);
    req = 4'b0000;
    cyc();
    // done in IDLE is ignored
    done = 1'b1;
    cyc();
    cyc();
    check("idle_done", gnt, 4'b0000);
    req = 4'b1000;
    cyc();
    check("idle_done_grant", gnt, 4'b1000);
    done = 1'b0;
    cyc();
    check("grant_holds", gnt, 4'b1000);
    req = 4'b0000;
    cyc();
    // any_req follows req with no clock in between
    for (int v = 0; v < 16; v++) begin
      req = 4'(v);
      #1;
      check("any_req_comb", {3'b0, any_req}, {3'b0, v != 0});
    end
    req = 4'b0000;
    cyc();
    for (int i = 0; i < 16; i++) begin
      {req, done} = mix[i];
      cyc();
    end
    req = 4'b0000;
    done = 1'b0;
    repeat (3) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
